// File: rtl/gyro_bias_filter.sv
// Gyro zero-rate bias calibration plus per-axis bias correction, saturation and IIR smoothing.
// Three identical axis lanes share one RUN/CAL controller that counts frames on the Z strobe.

module gyro_bias_axis #(
    parameter int CAL_LOG2   = 8,
    parameter int FILT_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] sample,
    input  logic               cal_clr,
    input  logic               cal_acc,
    input  logic               cal_latch,
    input  logic               run_vld,
    output logic signed [15:0] rate,
    output logic               rate_valid,
    output logic signed [15:0] bias
);
    localparam int AW = 16 + CAL_LOG2;

    logic signed [AW-1:0] acc, acc_sum, acc_avg;
    logic signed [16:0]   d, e, step;
    logic signed [15:0]   c, c_next, rate_next;
    logic [2:1]           vld_pipe;

    always_comb begin
        // The final frame's sample may land in the same cycle as the latch, so fold it in here.
        acc_sum = acc + (cal_acc ? {{CAL_LOG2{sample[15]}}, sample} : '0);
        acc_avg = acc_sum >>> CAL_LOG2;

        d = {sample[15], sample} - {bias[15], bias};
        if (d[16] != d[15])
            c_next = d[16] ? 16'sh8000 : 16'sh7fff;
        else
            c_next = d[15:0];

        e    = {c[15], c} - {rate[15], rate};
        step = e >>> FILT_SHIFT;
        if (FILT_SHIFT == 0)
            rate_next = c;
        else
            rate_next = rate + step[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            bias     <= '0;
            rate     <= '0;
            c        <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], run_vld};
            if (run_vld)
                c <= c_next;
            if (cal_clr)
                acc <= '0;
            else if (cal_acc)
                acc <= acc_sum;
            if (cal_latch) begin
                bias <= acc_avg[15:0];
                rate <= '0;
            end else if (vld_pipe[1]) begin
                rate <= rate_next;
            end
        end
    end

    assign rate_valid = vld_pipe[2];
endmodule

module gyro_bias_filter #(
    parameter int CAL_LOG2   = 8,
    parameter int FILT_SHIFT = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic signed [15:0] GYRO_X,
    input  logic signed [15:0] GYRO_Y,
    input  logic signed [15:0] GYRO_Z,
    input  logic               GYRO_X_VALID,
    input  logic               GYRO_Y_VALID,
    input  logic               GYRO_Z_VALID,
    input  logic               CAL_START,
    output logic               CAL_BUSY,
    output logic               CAL_DONE,
    output logic signed [15:0] RATE_X,
    output logic signed [15:0] RATE_Y,
    output logic signed [15:0] RATE_Z,
    output logic               RATE_X_VALID,
    output logic               RATE_Y_VALID,
    output logic               RATE_Z_VALID,
    output logic signed [15:0] BIAS_X,
    output logic signed [15:0] BIAS_Y,
    output logic signed [15:0] BIAS_Z
);
    localparam logic [CAL_LOG2:0] CNT_LAST = (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1);

    typedef enum logic {RUN, CAL} state_t;
    state_t state, state_next;

    logic [CAL_LOG2:0] cnt;
    logic              cal_last;
    logic [2:0][15:0]  gyro, rate, bias;
    logic [2:0]        gvld, rvld, run_vld, cal_acc;

    assign gyro = {GYRO_Z, GYRO_Y, GYRO_X};
    assign gvld = {GYRO_Z_VALID, GYRO_Y_VALID, GYRO_X_VALID};

    assign run_vld  = (state == RUN) ? gvld : 3'b000;
    // A sample coinciding with a (re)start request is dropped along with the old sums.
    assign cal_acc  = (state == CAL && !CAL_START) ? gvld : 3'b000;
    assign cal_last = (state == CAL) && GYRO_Z_VALID && !CAL_START && (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            RUN: if (CAL_START) state_next = CAL;
            CAL: if (cal_last)  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= RUN;
            cnt      <= '0;
            CAL_DONE <= 1'b0;
        end else begin
            state    <= state_next;
            CAL_DONE <= cal_last;
            if (CAL_START)
                cnt <= '0;
            else if (state == CAL && GYRO_Z_VALID)
                cnt <= cnt + 1'b1;
        end
    end

    for (genvar a = 0; a < 3; a++) begin : g_axis
        gyro_bias_axis #(
            .CAL_LOG2  (CAL_LOG2),
            .FILT_SHIFT(FILT_SHIFT)
        ) u_axis (
            .clk       (CLK),
            .rst_n     (RST_N),
            .sample    (gyro[a]),
            .cal_clr   (CAL_START),
            .cal_acc   (cal_acc[a]),
            .cal_latch (cal_last),
            .run_vld   (run_vld[a]),
            .rate      (rate[a]),
            .rate_valid(rvld[a]),
            .bias      (bias[a])
        );
    end

    assign CAL_BUSY     = (state == CAL);
    assign RATE_X       = rate[0];
    assign RATE_Y       = rate[1];
    assign RATE_Z       = rate[2];
    assign RATE_X_VALID = rvld[0];
    assign RATE_Y_VALID = rvld[1];
    assign RATE_Z_VALID = rvld[2];
    assign BIAS_X       = bias[0];
    assign BIAS_Y       = bias[1];
    assign BIAS_Z       = bias[2];
endmodule

// File: tb/tb_gyro_bias_filter.sv
// Directed bench: one unfiltered and one FILT_SHIFT=2 instance share stimulus, CAL_LOG2=2 (4 frames).

module tb_gyro_bias_filter;
    logic               CLK, RST_N, CAL_START;
    logic signed [15:0] gx, gy, gz;
    logic               vx, vy, vz;

    logic               busy0, done0, rxv0, ryv0, rzv0;
    logic signed [15:0] rx0, ry0, rz0, bx0, by0, bz0;
    logic               busy2, done2, rxv2, ryv2, rzv2;
    logic signed [15:0] rx2, ry2, rz2, bx2, by2, bz2;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int d0;
    int fexp [4] = '{100, 175, 231, 273};

    gyro_bias_filter #(.CAL_LOG2(2), .FILT_SHIFT(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .GYRO_X(gx), .GYRO_Y(gy), .GYRO_Z(gz),
        .GYRO_X_VALID(vx), .GYRO_Y_VALID(vy), .GYRO_Z_VALID(vz),
        .CAL_START(CAL_START), .CAL_BUSY(busy0), .CAL_DONE(done0),
        .RATE_X(rx0), .RATE_Y(ry0), .RATE_Z(rz0),
        .RATE_X_VALID(rxv0), .RATE_Y_VALID(ryv0), .RATE_Z_VALID(rzv0),
        .BIAS_X(bx0), .BIAS_Y(by0), .BIAS_Z(bz0)
    );

    gyro_bias_filter #(.CAL_LOG2(2), .FILT_SHIFT(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N),
        .GYRO_X(gx), .GYRO_Y(gy), .GYRO_Z(gz),
        .GYRO_X_VALID(vx), .GYRO_Y_VALID(vy), .GYRO_Z_VALID(vz),
        .CAL_START(CAL_START), .CAL_BUSY(busy2), .CAL_DONE(done2),
        .RATE_X(rx2), .RATE_Y(ry2), .RATE_Z(rz2),
        .RATE_X_VALID(rxv2), .RATE_Y_VALID(ryv2), .RATE_Z_VALID(rzv2),
        .BIAS_X(bx2), .BIAS_Y(by2), .BIAS_Z(bz2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (done0) done_cnt++;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_cal();
        CAL_START = 1'b1;
        step();
        CAL_START = 1'b0;
        chk("cal_busy_start", int'(busy0), 1);
    endtask

    // One calibration frame with all three axes strobed together.
    task automatic frame(input int x, input int y, input int z, input int last);
        gx = 16'(x); gy = 16'(y); gz = 16'(z);
        vx = 1'b1; vy = 1'b1; vz = 1'b1;
        step();
        vx = 1'b0; vy = 1'b0; vz = 1'b0;
        chk("cal_done", int'(done0), last);
        chk("cal_busy", int'(busy0), 1 - last);
        chk("cal_no_rate_vld", int'({rzv0, ryv0, rxv0}), 0);
    endtask

    initial begin
        RST_N = 1'b0; CAL_START = 1'b0;
        gx = '0; gy = '0; gz = '0; vx = 1'b0; vy = 1'b0; vz = 1'b0;
        step(); step();
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_rate_x", int'(rx0), 0);
        chk("rst_bias_x", int'(bx0), 0);
        chk("rst_rate_vld", int'({rzv0, ryv0, rxv0}), 0);
        RST_N = 1'b1;
        step();

        // IIR step response with zero bias
        gx = 16'sd400;
        for (int i = 0; i < 5; i++) begin
            vx = (i < 4);
            step();
            if (i >= 1) begin
                chk("filt_rate", int'(rx2), fexp[i-1]);
                chk("filt_vld", int'(rxv2), 1);
            end
        end
        vx = 1'b0;
        step();
        chk("filt_hold_vld", int'(rxv2), 0);
        chk("filt_hold_rate", int'(rx2), 273);
        chk("bypass_rate", int'(rx0), 400);

        // Calibration average
        start_cal();
        frame(100, -3, 0, 0);
        frame(102, -3, 0, 0);
        frame(98, -3, 0, 0);
        frame(100, -3, 0, 1);
        chk("bias_x", int'(bx0), 100);
        chk("bias_y", int'(by0), -3);
        chk("bias_z", int'(bz0), 0);
        chk("filt_clr0", int'(rx0), 0);
        chk("filt_clr2", int'(rx2), 0);
        step();
        chk("done_pulse_end", int'(done0), 0);

        // Correction and latency
        gx = 16'sd150; vx = 1'b1;
        step();
        vx = 1'b0;
        chk("lat_t1_vld", int'(rxv0), 0);
        step();
        chk("corr_rate_x", int'(rx0), 50);
        chk("corr_vld_x", int'(rxv0), 1);
        chk("corr_vld_yz", int'({rzv0, ryv0}), 0);
        chk("corr_rate_y", int'(ry0), 0);
        chk("corr_filt_x", int'(rx2), 12);

        // Simultaneous axes
        gx = 16'sd110; gy = 16'sd7; gz = 16'sd5;
        vx = 1'b1; vy = 1'b1; vz = 1'b1;
        step();
        vx = 1'b0; vy = 1'b0; vz = 1'b0;
        step();
        chk("sim_vld", int'({rzv0, ryv0, rxv0}), 7);
        chk("sim_rate_x", int'(rx0), 10);
        chk("sim_rate_y", int'(ry0), 10);
        chk("sim_rate_z", int'(rz0), 5);

        // CAL_START in RUN with a live sample: sample completes on the old bias
        CAL_START = 1'b1; gx = 16'sd150; gz = 16'sd5000; vx = 1'b1; vz = 1'b1;
        step();
        CAL_START = 1'b0; vx = 1'b0; vz = 1'b0;
        chk("start_busy", int'(busy0), 1);
        step();
        chk("start_old_bias_rate", int'(rx0), 50);
        chk("start_old_bias_vld", int'(rxv0), 1);
        frame(-100, 0, 0, 0);
        frame(-100, 0, 0, 0);
        frame(-100, 0, 0, 0);
        frame(-100, 0, 0, 1);
        chk("neg_bias_x", int'(bx0), -100);
        chk("neg_bias_z", int'(bz0), 0);

        // Positive saturation
        gx = 16'sd32700; vx = 1'b1;
        step();
        vx = 1'b0;
        step();
        chk("sat_pos", int'(rx0), 32767);

        // Restart mid-calibration; the Z strobe on the restart cycle must not count
        d0 = done_cnt;
        start_cal();
        frame(50, 0, 0, 0);
        frame(50, 0, 0, 0);
        CAL_START = 1'b1; gx = 16'sd1000; gz = 16'sd0; vx = 1'b1; vz = 1'b1;
        step();
        CAL_START = 1'b0; vx = 1'b0; vz = 1'b0;
        chk("restart_busy", int'(busy0), 1);
        chk("restart_done", int'(done0), 0);
        frame(8, 0, 0, 0);
        frame(8, 0, 0, 0);
        frame(8, 0, 0, 0);
        frame(8, 0, 0, 1);
        chk("restart_bias_x", int'(bx0), 8);
        step();
        chk("restart_single_done", done_cnt - d0, 1);

        // Negative saturation
        start_cal();
        frame(100, 0, 0, 0);
        frame(100, 0, 0, 0);
        frame(100, 0, 0, 0);
        frame(100, 0, 0, 1);
        gx = -16'sd32700; vx = 1'b1;
        step();
        vx = 1'b0;
        step();
        chk("sat_neg", int'(rx0), -32768);

        // Reset aborts calibration
        d0 = done_cnt;
        start_cal();
        frame(20, 0, 0, 0);
        frame(20, 0, 0, 0);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_bias_x", int'(bx0), 0);
        chk("abort_rate_x", int'(rx0), 0);
        repeat (4) step();
        chk("abort_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
